// File: rtl/waveform_capture.sv
// rtl/waveform_capture.sv - triggered ADC waveform capture with pre-trigger history and pulse height
//
// Ports:
//   clk         - single clock, all state updates on its rising edge
//   reset       - asynchronous active-high reset
//   adc_data    - unsigned 14-bit ADC sample, one per clk
//   threshold   - unsigned 14-bit trigger level (rising crossing)
//   enable      - 1 = arm and trigger, 0 = return to idle when not capturing
//   waveform    - NSAMP captured samples, index 0 oldest
//   acquire     - 0 while waveform/PulseHeight are stable and ready to send
//   PulseHeight - peak minus pre-trigger baseline, clamped at 0, zero-extended
//   trig_count  - number of accepted triggers, wraps
module waveform_capture #(
    parameter int NSAMP   = 32,
    parameter int PRETRIG = 4,
    parameter int HOLDOFF = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [13:0]             adc_data,
    input  logic [13:0]             threshold,
    input  logic                    enable,
    output logic [NSAMP-1:0][13:0]  waveform,
    output logic                    acquire,
    output logic [31:0]             PulseHeight,
    output logic [15:0]             trig_count
);

    localparam int PW = $clog2(PRETRIG);
    localparam int IW = $clog2(NSAMP);
    localparam int CW = IW + 1;
    localparam int HW = $clog2(HOLDOFF + 1);

    typedef enum logic [2:0] {IDLE, FILL, ARMED, CAPTURE, HOLD} state_t;

    state_t                     state;
    state_t                     state_nx;
    logic [PRETRIG-1:0][13:0]   hist;        // index PRETRIG-1 is the newest sample
    logic [PW:0]                fill_cnt;
    logic [CW-1:0]              cap_idx;     // next waveform slot; reaching NSAMP means done
    logic [HW-1:0]              hold_cnt;
    logic [13:0]                baseline;
    logic [13:0]                peak;
    logic [PW+13:0]             hist_sum;
    logic                       trig;
    logic                       fill_done;
    logic                       cap_done;
    logic                       hold_done;

    always_comb begin
        hist_sum = '0;
        for (int i = 0; i < PRETRIG; i++) begin
            hist_sum = hist_sum + (PW+14)'(hist[i]);
        end
    end

    // Rising crossing: previous registered sample below, current sample at or above.
    assign trig      = (state == ARMED) && enable &&
                       (hist[PRETRIG-1] < threshold) && (adc_data >= threshold);
    assign fill_done = (fill_cnt == (PW+1)'(PRETRIG - 1));
    assign cap_done  = (cap_idx == CW'(NSAMP));
    assign hold_done = (hold_cnt == HW'(HOLDOFF - 1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (enable) state_nx = FILL;
            FILL:    if (!enable) state_nx = IDLE;
                     else if (fill_done) state_nx = ARMED;
            ARMED:   if (!enable) state_nx = IDLE;
                     else if (trig) state_nx = CAPTURE;
            CAPTURE: if (cap_done) state_nx = HOLD;
            HOLD:    if (hold_done) state_nx = enable ? FILL : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist        <= '0;
            fill_cnt    <= '0;
            cap_idx     <= '0;
            hold_cnt    <= '0;
            baseline    <= '0;
            peak        <= '0;
            waveform    <= '0;
            acquire     <= 1'b1;
            PulseHeight <= '0;
            trig_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    fill_cnt <= '0;
                end
                FILL: begin
                    hist     <= {adc_data, hist[PRETRIG-1:1]};
                    fill_cnt <= fill_cnt + (PW+1)'(1);
                end
                ARMED: begin
                    hist <= {adc_data, hist[PRETRIG-1:1]};
                    if (trig) begin
                        waveform[PRETRIG-1:0] <= hist;
                        waveform[PRETRIG]     <= adc_data;
                        baseline              <= 14'(hist_sum >> PW);
                        peak                  <= adc_data;
                        trig_count            <= trig_count + 16'd1;
                        cap_idx               <= CW'(PRETRIG + 1);
                    end
                end
                CAPTURE: begin
                    if (cap_done) begin
                        PulseHeight <= (peak >= baseline) ? 32'(peak - baseline) : 32'd0;
                        acquire     <= 1'b0;
                        hold_cnt    <= '0;
                    end else begin
                        waveform[cap_idx[IW-1:0]] <= adc_data;
                        if (adc_data > peak) peak <= adc_data;
                        cap_idx <= cap_idx + CW'(1);
                    end
                end
                HOLD: begin
                    hold_cnt <= hold_cnt + HW'(1);
                    fill_cnt <= '0;
                    if (hold_done) acquire <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_waveform_capture.sv
// tb/tb_waveform_capture.sv - self-checking bench for waveform_capture against a sample-log reference model
module tb_waveform_capture;

    localparam int NSAMP   = 32;
    localparam int PRETRIG = 4;
    localparam int HOLDOFF = 8;
    localparam int WW      = NSAMP * 14;

    logic                   clk;
    logic                   clk_on;
    logic                   reset;
    logic [13:0]            adc_data;
    logic [13:0]            threshold;
    logic                   enable;
    logic [NSAMP-1:0][13:0] waveform;
    logic                   acquire;
    logic [31:0]            PulseHeight;
    logic [15:0]            trig_count;

    waveform_capture #(.NSAMP(NSAMP), .PRETRIG(PRETRIG), .HOLDOFF(HOLDOFF)) dut (
        .clk         (clk),
        .reset       (reset),
        .adc_data    (adc_data),
        .threshold   (threshold),
        .enable      (enable),
        .waveform    (waveform),
        .acquire     (acquire),
        .PulseHeight (PulseHeight),
        .trig_count  (trig_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 if (clk_on) clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: 0 idle, 1 arming (f samples taken), 2 capturing (k samples after trigger), 3 holding
    int                     mode;
    int                     f, k, h;
    int                     samples[$];
    logic [13:0]            base_m, mx_m;
    logic [NSAMP-1:0][13:0] exp_wave;
    logic [31:0]            exp_ph;
    logic                   exp_acq;
    logic [15:0]            exp_tc;

    task automatic model_reset();
        mode = 0; f = 0; k = 0; h = 0;
        samples.delete();
        base_m = '0; mx_m = '0;
        exp_wave = '0; exp_ph = '0; exp_acq = 1'b1; exp_tc = '0;
    endtask

    task automatic model_edge(input logic en, input logic [13:0] adc, input logic [13:0] thr);
        case (mode)
            0: if (en) begin mode = 1; f = 0; end
            1: if (!en) begin
                   mode = 0;
               end else begin
                   if (f >= PRETRIG && samples[$] < int'(thr) && adc >= thr) begin
                       int sum;
                       sum = 0;
                       for (int i = 1; i <= PRETRIG; i++) begin
                           sum += samples[samples.size()-i];
                           exp_wave[PRETRIG-i] = 14'(samples[samples.size()-i]);
                       end
                       exp_wave[PRETRIG] = adc;
                       base_m = 14'(sum / PRETRIG);
                       mx_m   = adc;
                       exp_tc = exp_tc + 16'd1;
                       mode   = 2;
                       k      = 1;
                   end
                   f++;
               end
            2: if (k < NSAMP - PRETRIG) begin
                   exp_wave[PRETRIG+k] = adc;
                   if (adc > mx_m) mx_m = adc;
                   k++;
               end else begin
                   exp_ph  = (mx_m > base_m) ? 32'(mx_m - base_m) : 32'd0;
                   exp_acq = 1'b0;
                   mode    = 3;
                   h       = 0;
               end
            3: begin
                   h++;
                   if (h == HOLDOFF) begin
                       exp_acq = 1'b1;
                       if (en) begin mode = 1; f = 0; end
                       else mode = 0;
                   end
               end
            default: mode = 0;
        endcase
        samples.push_back(int'(adc));
        if (samples.size() > 16) void'(samples.pop_front());
    endtask

    task automatic check_all(input string tag);
        check({tag, ".acquire"},    WW'(acquire),     WW'(exp_acq));
        check({tag, ".trig_count"}, WW'(trig_count),  WW'(exp_tc));
        check({tag, ".pulse"},      WW'(PulseHeight), WW'(exp_ph));
        check({tag, ".waveform"},   WW'(waveform),    WW'(exp_wave));
    endtask

    task automatic tick(input logic en, input logic [13:0] adc, input logic [13:0] thr);
        enable = en; adc_data = adc; threshold = thr;
        @(posedge clk);
        model_edge(en, adc, thr);
        #1;
        check_all("cyc");
    endtask

    int lat;
    int low;

    initial begin
        clk_on = 1'b0;
        reset = 1'b0; enable = 1'b0; adc_data = '0; threshold = '0;
        model_reset();

        // Reset with the clock stopped
        #3 reset = 1'b1;
        #1 check_all("reset");
        #5 reset = 1'b0;
        clk_on = 1'b1;
        #2;

        // Step pulse: 100 x10 then 2000
        for (int i = 0; i < 10; i++) tick(1, 14'd100, 14'd500);
        tick(1, 14'd2000, 14'd500);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            tick(1, 14'd2000, 14'd500);
            if (acquire == 1'b0) begin lat = i; break; end
        end
        check("step_latency", WW'(lat), WW'(28));
        check("step_wave0",   WW'(waveform[0]),  WW'(100));
        check("step_wave3",   WW'(waveform[3]),  WW'(100));
        check("step_wave4",   WW'(waveform[4]),  WW'(2000));
        check("step_wave31",  WW'(waveform[31]), WW'(2000));
        check("step_ph",      WW'(PulseHeight),  WW'(1900));
        check("step_tc",      WW'(trig_count),   WW'(1));

        // Holdoff length, then a second step after refill
        low = 1;
        for (int i = 0; i < 20; i++) begin
            tick(1, 14'd2000, 14'd500);
            if (acquire == 1'b0) low++;
            else break;
        end
        check("holdoff_len", WW'(low), WW'(HOLDOFF));
        for (int i = 0; i < 8; i++) tick(1, 14'd100, 14'd500);
        tick(1, 14'd2000, 14'd500);
        check("second_tc", WW'(trig_count), WW'(2));
        for (int i = 0; i < 45; i++) tick(0, 14'd2000, 14'd500);

        // No crossing: level stays above threshold; then disable while armed
        for (int i = 0; i < 30; i++) tick(1, 14'd600, 14'd500);
        check("nocross_acq", WW'(acquire),    WW'(1));
        check("nocross_tc",  WW'(trig_count), WW'(2));
        for (int i = 0; i < 3; i++) tick(0, 14'd100, 14'd500);
        tick(0, 14'd2000, 14'd500);
        check("disabled_tc", WW'(trig_count), WW'(2));

        // Negative pulse: baseline above the peak clamps to 0; crossing in hold ignored
        for (int i = 0; i < 8; i++) tick(1, 14'd1200, 14'd1000);
        tick(1, 14'd999, 14'd1000);
        tick(1, 14'd1000, 14'd1000);
        for (int i = 0; i < 28; i++) tick(1, 14'd200, 14'd1000);
        check("neg_ph",  WW'(PulseHeight), WW'(0));
        check("neg_acq", WW'(acquire),     WW'(0));
        tick(1, 14'd200, 14'd1000);
        tick(1, 14'd1500, 14'd1000);
        check("hold_cross_tc", WW'(trig_count), WW'(3));
        for (int i = 0; i < 10; i++) tick(0, 14'd200, 14'd1000);

        // Reset ten edges into a capture
        for (int i = 0; i < 8; i++) tick(1, 14'd100, 14'd500);
        tick(1, 14'd2000, 14'd500);
        for (int i = 0; i < 10; i++) tick(1, 14'd2100, 14'd500);
        #2 reset = 1'b1;
        model_reset();
        #1 check_all("midreset");
        @(posedge clk);
        #1 check_all("midreset_hold");
        reset = 1'b0;
        tick(1, 14'd100, 14'd500);
        for (int i = 0; i < 3; i++) tick(1, 14'd100, 14'd500);
        tick(1, 14'd2000, 14'd500);
        check("refill_no_trig", WW'(trig_count), WW'(0));
        for (int i = 0; i < 4; i++) tick(1, 14'd100, 14'd500);
        tick(1, 14'd2000, 14'd500);
        check("refill_trig", WW'(trig_count), WW'(1));
        for (int i = 0; i < 40; i++) tick(1, 14'd2000, 14'd500);

        // Randomized traffic around a threshold
        for (int i = 0; i < 1500; i++) begin
            logic        en;
            logic [13:0] a;
            en = ($urandom_range(0, 29) != 0);
            a  = $urandom_range(0, 1) ? 14'($urandom_range(0, 999)) : 14'($urandom_range(1000, 16383));
            tick(en, a, 14'd1000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
